// File: rtl/valve_cmd_tx_pkg.sv
// Shared fiber command definitions: frame constants, cmd bit layout, cmd builder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a. The unit-side receiver imports the same package.
package valve_cmd_tx_pkg;

    localparam int         FRAME_BITS  = 18;      // start + 8 cmd + 8 chk + stop
    localparam logic [2:0] CMD_MARKER  = 3'b101;  // fixed pattern in cmd[7:5]

    localparam int CMD_RUN     = 0;
    localparam int CMD_IGBT_LO = 1;
    localparam int CMD_BYP     = 3;
    localparam int CMD_RST     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STOP
    } tx_state_e;

    function automatic logic [7:0] build_cmd(input logic       run,
                                             input logic [1:0] igbt,
                                             input logic       byp,
                                             input logic       rst);
        logic [7:0] c;
        c                    = '0;
        c[CMD_RUN]           = run;
        c[CMD_IGBT_LO +: 2]  = igbt;
        c[CMD_BYP]           = byp;
        c[CMD_RST]           = rst;
        c[7:5]               = CMD_MARKER;
        return c;
    endfunction

endpackage

// File: rtl/valve_cmd_tx_bit_timer.sv
// Bit-period down-counter producing one bit_end strobe every CLKS_PER_BIT running cycles.
// Latency: restart_i reloads the count; first bit_end comes CLKS_PER_BIT run cycles later.
// Backpressure: none; counts only while run_i is high.
// Ports: clk, rst (async, active high), restart_i (reload), run_i (count enable),
//        bit_end_o (last cycle of the current bit).
module fiber_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic run_i,
    output logic bit_end_o
);

    localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else if (restart_i || (run_i && cnt_q == 8'd0)) begin
            cnt_q <= RELOAD;
        end else if (run_i) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign bit_end_o = run_i && (cnt_q == 8'd0);

endmodule

// File: rtl/valve_cmd_tx.sv
// Valve-side fiber command transmitter: periodic snapshot of the command set sent as an NRZ frame.
// Latency: start bit leaves 2 clk after a frame request is raised; frame lasts 18*CLKS_PER_BIT clk.
// Backpressure: none; a request raised while busy is held (one deep) and sent right after the frame.
// Ports: clk, rst (async, active high), time_1us (1 us strobe), tx_en, start_stop, igbt_control[1:0],
//        bypcon, reset_req (pulse) -> busy, frame_sent (pulse after stop bit), COMM_T (idle-high line).
module valve_cmd_tx #(
    parameter int CLKS_PER_BIT    = 8,
    parameter int FRAME_PERIOD_US = 10,
    parameter int RESET_FRAMES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       time_1us,
    input  logic       tx_en,
    input  logic       start_stop,
    input  logic [1:0] igbt_control,
    input  logic       bypcon,
    input  logic       reset_req,
    output logic       busy,
    output logic       frame_sent,
    output logic       COMM_T
);

    import valve_cmd_tx_pkg::*;

    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 2);  // start bit + 16 payload bits

    tx_state_e   state_q;
    logic [7:0]  per_cnt_q;
    logic        pend_q;
    logic [7:0]  stretch_q;
    logic [4:0]  bit_cnt_q;
    logic [15:0] sreg_q;
    logic        comm_q;
    logic        busy_q;
    logic        sent_q;

    logic        load;
    logic        period_hit;
    logic        bit_end;
    logic        rst_flag_d;
    logic [7:0]  cmd_d;

    assign load       = (state_q == ST_LOAD);
    assign period_hit = tx_en && time_1us && (per_cnt_q == 8'(FRAME_PERIOD_US - 1));
    // A reset_req landing on the LOAD cycle itself still flags this frame.
    assign rst_flag_d = reset_req || (stretch_q != 8'd0);
    assign cmd_d      = build_cmd(start_stop, igbt_control, bypcon, rst_flag_d);

    fiber_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .restart_i (load),
        .run_i     (state_q == ST_SHIFT || state_q == ST_STOP),
        .bit_end_o (bit_end)
    );

    // Frame cadence; a new request arriving in the LOAD cycle is kept, not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else if (!tx_en) begin
            per_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            if (time_1us) begin
                per_cnt_q <= period_hit ? 8'd0 : per_cnt_q + 8'd1;
            end
            if (period_hit) begin
                pend_q <= 1'b1;
            end else if (load) begin
                pend_q <= 1'b0;
            end
        end
    end

    // Reset stretch: a reload coincident with LOAD counts the current frame as the first one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stretch_q <= '0;
        end else if (reset_req) begin
            stretch_q <= load ? 8'(RESET_FRAMES - 1) : 8'(RESET_FRAMES);
        end else if (load && stretch_q != 8'd0) begin
            stretch_q <= stretch_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
            comm_q    <= 1'b1;
            busy_q    <= 1'b0;
            sent_q    <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    sreg_q    <= {~cmd_d, cmd_d};
                    comm_q    <= 1'b0;  // start bit
                    bit_cnt_q <= '0;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_end) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            comm_q  <= 1'b1;  // stop bit
                            state_q <= ST_STOP;
                        end else begin
                            comm_q    <= sreg_q[0];
                            sreg_q    <= sreg_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        sent_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign frame_sent = sent_q;
    assign COMM_T     = comm_q;

endmodule

// File: doc/valve_cmd_tx.md
Name: valve_cmd_tx

Overview:
- Valve-control-side fiber command transmitter; the far end of the unit's fiber receive path.
- Periodically snapshots the unit command set (run, IGBT control, bypass, fault reset) and serializes it as a self-checking NRZ frame on the optical TX line.
- A frame gap longer than 20 us on the unit side is treated as fiber loss, so frame cadence is mandatory while enabled.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per serial bit (40 MHz clk gives 5 Mbit/s); legal range 2..255.
- FRAME_PERIOD_US, 10, frame start interval in time_1us ticks; legal range 5..255.
- RESET_FRAMES, 3, number of consecutive frames that carry the reset bit after one reset_req pulse.

Ports:
- clk  in  1  system clock, 40 MHz
- rst  in  1  asynchronous, active-high reset
- time_1us  in  1  one-clk strobe every 1 us, from div_1us
- tx_en  in  1  1 = periodic transmission; 0 = line held idle-high after the current frame completes
- start_stop  in  1  run command
- igbt_control  in  2  bridge state command
- bypcon  in  1  bypass-close command
- reset_req  in  1  one-clk pulse requesting a unit fault reset
- busy  out  1  high while a frame is shifting
- frame_sent  out  1  one-clk pulse in the cycle after the stop bit ends
- COMM_T  out  1  serial fiber output, idle high

Behaviour:
- Reset values: COMM_T=1, busy=0, frame_sent=0. Period counter, reset stretch counter, pending flag and FSM all clear; FSM goes to IDLE.
- Frame format, 18 bits:
  - start bit 0
  - cmd[7:0], LSB first; then chk[7:0] = ~cmd, LSB first
  - stop bit 1
  - Each bit lasts exactly CLKS_PER_BIT clk cycles.
- cmd bit mapping: [0]=start_stop, [2:1]=igbt_control, [3]=bypcon, [4]=reset flag, [7:5]=3'b101 (fixed marker).
- Period counter:
  - Counts time_1us strobes while tx_en=1.
  - On the strobe where the count equals FRAME_PERIOD_US-1: counter wraps to 0 and the pending flag is set.
  - While tx_en=0 the counter is held at 0 and pending is cleared.
- FSM states: IDLE, LOAD, SHIFT, STOP.
  - IDLE -> LOAD when pending=1. In LOAD, all command inputs are snapshotted into the shift register and pending is cleared. LOAD lasts 1 cycle.
  - LOAD -> SHIFT. The start bit drives COMM_T from the first SHIFT cycle. A bit counter runs 0..16, covering the start bit plus 16 payload bits.
  - SHIFT -> STOP after bit 16 has been held CLKS_PER_BIT cycles. STOP drives 1 for CLKS_PER_BIT cycles.
  - STOP -> IDLE, with frame_sent pulsed for one cycle.
  - busy = 1 in LOAD, SHIFT and STOP.
- Timing: latency from the pending set to the first start-bit cycle is 2 clk. Frame length is 18*CLKS_PER_BIT clk.
- Pending during busy: if pending sets while busy, it is held and serviced on the IDLE cycle after the frame. At most one request is held; a second request before service is absorbed.
- Reset stretch:
  - reset_req loads the stretch counter with RESET_FRAMES.
  - The reset flag in cmd = (stretch counter != 0), evaluated at LOAD.
  - The counter decrements on each LOAD while nonzero.
  - reset_req arriving in the same cycle as LOAD: the reload wins and that frame carries reset=1.
- tx_en falling mid-frame: the current frame completes normally, and no new frame starts.
- rst asserted mid-frame: COMM_T is forced to 1 immediately (asynchronously). The partial frame is abandoned; the receiver sees a checksum or format error, which is acceptable.
- Command inputs are sampled only at LOAD. Changes during SHIFT do not affect the frame in flight.

Decomposition:
- Shared fiber package holds:
  - constants FRAME_BITS=18, CMD_MARKER=3'b101
  - cmd bit-index constants CMD_RUN=0, CMD_IGBT_LO=1, CMD_BYP=3, CMD_RST=4
  - a function build_cmd(run, igbt, byp, rst) returning 8 bits. The unit-side receiver reuses the same package.
- One natural sub-module: fiber_bit_timer, a CLKS_PER_BIT down-counter generating bit_end strobes, restarted at LOAD.

Test Plan:
- Run frame: tx_en=1, start_stop=1, igbt_control=2'b10, bypcon=0, no reset -> cmd=8'hA5, chk=8'h5A. COMM_T is 0,1,0,1,0,0,1,0,1 then 0,1,0,1,1,0,1,0 then 1, each 8 clk. frame_sent pulses once.
- Cadence: tx_en=1 for 100 us -> exactly 10 frames. Start-bit falling edges are 400 clk apart (10 us at 40 MHz). Line is high between frames.
- Reset stretch: single reset_req pulse -> next 3 frames have cmd[4]=1 and the 4th has cmd[4]=0. A pulse coincident with LOAD still yields 3 frames including the current one.
- Disable: drop tx_en at bit 5 of a frame -> frame completes with a valid stop bit, then COMM_T stays 1 for 50 us with no frame_sent.
- Mid-frame reset: assert rst at bit 9 -> COMM_T=1 in the same cycle and busy=0. After release with tx_en=1, the first start bit appears 10 us (FRAME_PERIOD_US) plus 2 clk later.
- Input change in flight: toggle start_stop during SHIFT -> the transmitted cmd[0] equals the LOAD-time value, and the next frame carries the new value.
